word_to_halves: RTL and testbench

Reads a full N-bit word from an upstream producer and delivers it as two N/2-bit halves over a half-width bus, tagging each half as high or low. It is the unloading end of the split high/low register path: each output beat maps directly onto a `loadh`/`loadl` write of a half-word register on the far side. Valid/ready handshakes on both sides give back-pressure and sustain one word every two cycles.

---
 rtl/word_to_halves.sv | 118 +++++++++++
 tb/tb_word_to_halves.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/word_to_halves.sv
// Splits an N-bit word into two N/2-bit beats tagged high/low, with valid/ready
// on both sides and a back-to-back reload path that sustains one word every two cycles.
module word_to_halves #(
  parameter int N        = 16,
  parameter int HI_FIRST = 1,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic [N-1:0]       in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N/2-1:0]     out_half,
  output logic               out_hi,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   words_done
);

  localparam int H = N / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [N-1:0]     buf_r, buf_nxt_s;
  logic [CNT_W-1:0] words_r, words_nxt_s;
  logic [H-1:0]     half_r, half_nxt_s;
  logic             hi_r, hi_nxt_s;
  logic             valid_r, valid_nxt_s;

  // Returns {out_hi, out_half} for the beat a given state presents from a word.
  function automatic logic [H:0] pick_half(input state_t st, input logic [N-1:0] w);
    logic upper;
    upper = 1'b0;
    case (st)
      FIRST:   upper = (HI_FIRST != 0);
      SECOND:  upper = (HI_FIRST == 0);
      default: upper = 1'b0;
    endcase
    if (st == IDLE) begin
      pick_half = {1'b0, {H{1'b0}}};
    end else begin
      pick_half = {upper, (upper ? w[N-1:H] : w[H-1:0])};
    end
  endfunction

  // Next-state, holding-register and counter logic; outputs are precomputed
  // from the next state so they leave the block straight from flops.
  always_comb begin
    state_nxt_s = state_r;
    buf_nxt_s   = buf_r;
    words_nxt_s = words_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          buf_nxt_s   = in_word;
          state_nxt_s = FIRST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FIRST: begin
        if (out_ready) begin
          state_nxt_s = SECOND;
        end else begin
          state_nxt_s = FIRST;
        end
      end
      SECOND: begin
        if (out_ready) begin
          words_nxt_s = words_r + CNT_W'(1);
          if (in_valid) begin
            buf_nxt_s   = in_word;
            state_nxt_s = FIRST;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = SECOND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    {hi_nxt_s, half_nxt_s} = pick_half(state_nxt_s, buf_nxt_s);
    valid_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r <= IDLE;
      buf_r   <= '0;
      words_r <= '0;
      half_r  <= '0;
      hi_r    <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      buf_r   <= buf_nxt_s;
      words_r <= words_nxt_s;
      half_r  <= half_nxt_s;
      hi_r    <= hi_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Handshakes are masked while clear is held so nothing moves during reset.
  assign in_ready   = clear_n & ((state_r == IDLE) | ((state_r == SECOND) & out_ready));
  assign out_valid  = clear_n & valid_r;
  assign out_half   = half_r;
  assign out_hi     = hi_r;
  assign words_done = words_r;

endmodule

// File: tb/tb_word_to_halves.sv
// Drives two word_to_halves instances (high-first/8-bit counter and low-first/2-bit
// counter) with shared stimulus and compares them against a queue-of-beats model.
module tb_word_to_halves;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, out_hi_a, out_valid_a;
  logic [7:0]  out_half_a, words_done_a;
  logic        in_ready_b, out_hi_b, out_valid_b;
  logic [7:0]  out_half_b;
  logic [1:0]  words_done_b;

  typedef struct packed {
    logic        last;
    logic [15:0] w;
  } beat_t;

  beat_t model_q[$];
  int    cnt_model;
  int    tests_run;
  int    tests_failed;
  int    beats_seen;

  always #5 clk = ~clk;

  word_to_halves #(.N(16), .HI_FIRST(1), .CNT_W(8)) dut_a (
    .clk(clk), .clear_n(clear_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_half(out_half_a), .out_hi(out_hi_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .words_done(words_done_a)
  );

  word_to_halves #(.N(16), .HI_FIRST(0), .CNT_W(2)) dut_b (
    .clk(clk), .clear_n(clear_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_half(out_half_b), .out_hi(out_hi_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .words_done(words_done_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check mid-cycle against the model, advance model at the edge.
  task automatic step(input logic rst_v, input logic iv, input logic [15:0] w, input logic ordy);
    logic  exp_ir, exp_ov, in_x, out_x;
    beat_t b;
    clear_n   = rst_v;
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
    #4;
    if (!rst_v) begin
      exp_ir = 1'b0;
      exp_ov = 1'b0;
    end else begin
      exp_ov = (model_q.size() > 0);
      exp_ir = (model_q.size() == 0) || (model_q.size() == 1 && ordy);
    end
    check("in_ready_a", {15'd0, in_ready_a}, {15'd0, exp_ir});
    check("in_ready_b", {15'd0, in_ready_b}, {15'd0, exp_ir});
    check("out_valid_a", {15'd0, out_valid_a}, {15'd0, exp_ov});
    check("out_valid_b", {15'd0, out_valid_b}, {15'd0, exp_ov});
    if (rst_v && exp_ov) begin
      b = model_q[0];
      check("half_a", {8'd0, out_half_a}, {8'd0, (b.last ? b.w[7:0] : b.w[15:8])});
      check("hi_a", {15'd0, out_hi_a}, {15'd0, ~b.last});
      check("half_b", {8'd0, out_half_b}, {8'd0, (b.last ? b.w[15:8] : b.w[7:0])});
      check("hi_b", {15'd0, out_hi_b}, {15'd0, b.last});
    end else if (rst_v) begin
      check("idle_half_a", {8'd0, out_half_a}, 16'd0);
      check("idle_hi_a", {15'd0, out_hi_a}, 16'd0);
    end
    check("words_a", {8'd0, words_done_a}, 16'(cnt_model % 256));
    check("words_b", {14'd0, words_done_b}, 16'(cnt_model % 4));
    if (out_valid_a && ordy) beats_seen++;
    if (!rst_v) begin
      model_q.delete();
      cnt_model = 0;
    end else begin
      out_x = exp_ov && ordy;
      in_x  = iv && exp_ir;
      if (out_x) begin
        b = model_q.pop_front();
        if (b.last) cnt_model++;
      end
      if (in_x) begin
        model_q.push_back('{last: 1'b0, w: w});
        model_q.push_back('{last: 1'b1, w: w});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats0;
    tests_run = 0; tests_failed = 0; cnt_model = 0; beats_seen = 0;
    clear_n = 1'b0; in_valid = 1'b0; in_word = 16'd0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset and idle
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);

    // Single word: A gives A5/1 then 5A/0
    step(1'b1, 1'b1, 16'hA55A, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check("single_done_a", {8'd0, words_done_a}, 16'd1);

    // Back-to-back: second word accepted during the second beat of the first
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 16'h1234, 1'b1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check("b2b_done_b", {14'd0, words_done_b}, 16'd2);

    // Back-pressure: stalls in FIRST and SECOND, exactly two beats
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    beats0 = beats_seen;
    step(1'b1, 1'b1, 16'hC3F0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h5555, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 16'h6666, 1'b0);
    step(1'b1, 1'b0, 16'h6666, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check("bp_beats", 16'(beats_seen - beats0), 16'd2);

    // Reset mid-word: second half of 7E81 must never appear
    step(1'b1, 1'b1, 16'h7E81, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 16'h0102, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);

    // Counter wrap on the 2-bit counter after five words
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 16'($urandom), 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    check("wrap_b", {14'd0, words_done_b}, 16'd1);
    check("wrap_a", {8'd0, words_done_a}, 16'd5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
